// File: rtl/hazard_track.sv
// Load-use hazard scoreboard that tracks the destination of the instructions in EX, ME and WB.
// It drives the forwarding valids and stalls ID for one cycle when ID consumes a load that is still in EX.
module hazard_track #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic [REG_W-1:0] id_rdst,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [REG_W-1:0] id_rsrc1,
    input  logic [REG_W-1:0] id_rsrc2,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [REG_W-1:0] ex_rdst,
    output logic             me_valid,
    output logic [REG_W-1:0] me_rdst,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rdst,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             v;
        logic             load;
        logic [REG_W-1:0] rdst;
    } slot_t;

    slot_t            ex_q, me_q, wb_q;
    slot_t            ex_d, me_d, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             haz_d;
    logic             stall_d;
    logic             accept_d;

    function automatic logic reads_reg(input logic             use_src,
                                       input logic [REG_W-1:0] rsrc,
                                       input logic [REG_W-1:0] rdst);
        reads_reg = use_src & (rsrc == rdst);
    endfunction

    // Hazard detection, next-slot state and saturating stall counter.
    always_comb begin
        haz_d       = 1'b0;
        stall_d     = 1'b0;
        accept_d    = 1'b0;
        ex_d        = '0;
        me_d        = ex_q;
        wb_d        = me_q;
        stall_cnt_d = stall_cnt_q;

        if (id_valid && ex_q.v && ex_q.load) begin
            haz_d = reads_reg(id_use1, id_rsrc1, ex_q.rdst) |
                    reads_reg(id_use2, id_rsrc2, ex_q.rdst);
        end else begin
            haz_d = 1'b0;
        end

        // A squashed instruction never stalls, so flush masks the hazard.
        stall_d  = haz_d & ~flush;
        accept_d = id_valid & id_wr & ~flush;

        if (stall_d) begin
            ex_d = '0;
        end else begin
            ex_d.v    = accept_d;
            ex_d.load = accept_d & id_load;
            ex_d.rdst = id_rdst;
        end

        if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Pipeline slot and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            me_q        <= '0;
            wb_q        <= '0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q        <= ex_d;
            me_q        <= me_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_d;
    assign ex_valid  = ex_q.v;
    assign ex_rdst   = ex_q.rdst;
    // A load in ME has no data yet, so it is hidden from the forwarding unit.
    assign me_valid  = me_q.v & ~me_q.load;
    assign me_rdst   = me_q.rdst;
    assign wb_valid  = wb_q.v;
    assign wb_rdst   = wb_q.rdst;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_track.sv
// Directed bench for hazard_track: stimulus pushes hand-computed expectations into a queue,
// and a monitor checks them each cycle on a default instance and on a 2-bit-counter instance.
module tb_hazard_track;

    logic        clk;
    logic        rst;
    logic        id_valid, id_wr, id_load, id_use1, id_use2, flush;
    logic [2:0]  id_rdst, id_rsrc1, id_rsrc2;
    logic        stall, ex_valid, me_valid, wb_valid;
    logic [2:0]  ex_rdst, me_rdst, wb_rdst;
    logic [15:0] stall_cnt;
    logic        s_stall, s_ex_valid, s_me_valid, s_wb_valid;
    logic [2:0]  s_ex_rdst, s_me_rdst, s_wb_rdst;
    logic [1:0]  s_stall_cnt;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    typedef struct {
        int         idx;
        logic       stall;
        logic       exv;
        logic [2:0] exr;
        logic       mev;
        logic [2:0] mer;
        logic       wbv;
        logic [2:0] wbr;
        logic [15:0] cnt;
        logic [1:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    hazard_track dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wr(id_wr), .id_load(id_load),
        .id_rdst(id_rdst), .id_use1(id_use1), .id_use2(id_use2), .id_rsrc1(id_rsrc1),
        .id_rsrc2(id_rsrc2), .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_rdst(ex_rdst), .me_valid(me_valid), .me_rdst(me_rdst), .wb_valid(wb_valid),
        .wb_rdst(wb_rdst), .stall_cnt(stall_cnt)
    );

    hazard_track #(.REG_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wr(id_wr), .id_load(id_load),
        .id_rdst(id_rdst), .id_use1(id_use1), .id_use2(id_use2), .id_rsrc1(id_rsrc1),
        .id_rsrc2(id_rsrc2), .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid),
        .ex_rdst(s_ex_rdst), .me_valid(s_me_valid), .me_rdst(s_me_rdst), .wb_valid(s_wb_valid),
        .wb_rdst(s_wb_rdst), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int idx, input string nm, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL step=%0d %s actual=%0h expected=%0h", idx, nm, act, expv);
        end
    endtask

    // Monitor: compares the outputs against the oldest pending expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk(mon_e.idx, "stall",        {15'd0, stall},       {15'd0, mon_e.stall});
            chk(mon_e.idx, "ex_valid",     {15'd0, ex_valid},    {15'd0, mon_e.exv});
            chk(mon_e.idx, "ex_rdst",      {13'd0, ex_rdst},     {13'd0, mon_e.exr});
            chk(mon_e.idx, "me_valid",     {15'd0, me_valid},    {15'd0, mon_e.mev});
            chk(mon_e.idx, "me_rdst",      {13'd0, me_rdst},     {13'd0, mon_e.mer});
            chk(mon_e.idx, "wb_valid",     {15'd0, wb_valid},    {15'd0, mon_e.wbv});
            chk(mon_e.idx, "wb_rdst",      {13'd0, wb_rdst},     {13'd0, mon_e.wbr});
            chk(mon_e.idx, "stall_cnt",    stall_cnt,            mon_e.cnt);
            chk(mon_e.idx, "sat_stall",    {15'd0, s_stall},     {15'd0, mon_e.stall});
            chk(mon_e.idx, "sat_stall_cnt",{14'd0, s_stall_cnt}, {14'd0, mon_e.scnt});
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic r, input logic v, input logic wr, input logic ld, input logic [2:0] rd,
                        input logic u1, input logic [2:0] s1, input logic u2, input logic [2:0] s2,
                        input logic fl,
                        input logic e_st, input logic e_exv, input logic [2:0] e_exr,
                        input logic e_mev, input logic [2:0] e_mer, input logic e_wbv, input logic [2:0] e_wbr,
                        input logic [15:0] e_cnt, input logic [1:0] e_scnt);
        exp_t e;
        rst = r; id_valid = v; id_wr = wr; id_load = ld; id_rdst = rd;
        id_use1 = u1; id_rsrc1 = s1; id_use2 = u2; id_rsrc2 = s2; flush = fl;
        step_no++;
        e.idx = step_no; e.stall = e_st; e.exv = e_exv; e.exr = e_exr; e.mev = e_mev;
        e.mer = e_mer; e.wbv = e_wbv; e.wbr = e_wbr; e.cnt = e_cnt; e.scnt = e_scnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_wr = 1'b0; id_load = 1'b0; id_rdst = 3'd0;
        id_use1 = 1'b0; id_rsrc1 = 3'd0; id_use2 = 1'b0; id_rsrc2 = 3'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //   rst   vld   wr    ld    rd    u1    s1    u2    s2    fl  | st    exv   exr   mev   mer   wbv   wbr   cnt     scnt
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0, 2'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0, 2'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 3'd3, 1'b0, 3'd0, 16'd0, 2'd0);
        // load r5, then a reader of r5 on rsrc2 stalls once
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd3, 16'd0, 2'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 3'd1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1, 3'd4, 16'd0, 2'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 3'd1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 3'd0, 16'd1, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 3'd0, 1'b1, 3'd5, 16'd1, 2'd1);
        // load r7, then a reader of r7 that is flushed: no stall, EX goes invalid
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0, 3'd0, 16'd1, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 3'd7, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b1, 3'd6, 16'd1, 2'd1);
        // load r2, then rsrc1=2 with use1=0: no stall
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'd7, 1'b0, 3'd0, 16'd1, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 3'd2, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd2, 1'b1, 3'd7, 16'd1, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 3'd2, 1'b0, 3'd2, 16'd1, 2'd1);
        // chain of dependent loads starting at r0; saturating counter goes 2,3,3,3
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 3'd2, 16'd1, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 16'd1, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'd2, 2'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd0, 16'd2, 2'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 3'd0, 16'd3, 2'd3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 3'd0, 1'b1, 3'd3, 16'd3, 2'd3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 3'd0, 16'd4, 2'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1, 3'd4, 16'd4, 2'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 3'd0, 16'd5, 2'd3);
        // reset mid-stream discards everything
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 3'd0, 1'b1, 3'd5, 16'd5, 2'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'd0, 2'd0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
